// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide unit: MULT_CYCLES/DIV_CYCLES busy window, then commit; mthi/mtlo are single-cycle.
// A start while busy is ignored; the hazard unit gets md_stall. MDU_DIV0_FAST_EN completes divide-by-zero at once.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

`ifdef MDU_DIV0_FAST_EN
  localparam bit DIV0_FAST = 1'b1;
`else
  localparam bit DIV0_FAST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [31:0]        tmp_hi, tmp_lo;
  logic               tmp_wr;
  logic               is_mul, is_div, div0, accept, commit, load_mul, load_div;
  logic [31:0]        b_safe, quo_s, rem_s, quo_u, rem_u;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;

  always_comb begin
    is_mul = (mdop == OP_MULT) || (mdop == OP_MULTU);
    is_div = (mdop == OP_DIV)  || (mdop == OP_DIVU);
    div0   = (B == 32'd0);
    accept = start && (state == IDLE);
    commit = (state != IDLE) && (cnt == CNT_W'(1));
  end

  // Divisor forced to 1 on zero so the dividers never see /0; the result is discarded anyway.
  always_comb begin
    b_safe = div0 ? 32'd1 : B;
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'd0, A} * {32'd0, B};
    quo_s  = 32'($signed(A) / $signed(b_safe));
    rem_s  = 32'($signed(A) % $signed(b_safe));
    quo_u  = A / b_safe;
    rem_u  = A % b_safe;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_mul  = 1'b0;
    load_div  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && is_mul) begin
          state_nxt = MULT;
          cnt_nxt   = CNT_W'(MULT_CYCLES);
          load_mul  = 1'b1;
        end else if (accept && is_div && !(DIV0_FAST && div0)) begin
          state_nxt = DIV;
          cnt_nxt   = CNT_W'(DIV_CYCLES);
          load_div  = 1'b1;
        end
      end
      default: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      HI     <= '0;
      LO     <= '0;
      tmp_hi <= '0;
      tmp_lo <= '0;
      tmp_wr <= 1'b0;
    end else begin
      if (load_mul) begin
        tmp_hi <= (mdop == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
        tmp_lo <= (mdop == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
        tmp_wr <= 1'b1;
      end
      // A zero divisor still runs the busy window but never commits.
      if (load_div) begin
        tmp_hi <= (mdop == OP_DIV) ? rem_s : rem_u;
        tmp_lo <= (mdop == OP_DIV) ? quo_s : quo_u;
        tmp_wr <= !div0;
      end
      if (commit && tmp_wr) begin
        HI <= tmp_hi;
        LO <= tmp_lo;
      end
      if (accept && (mdop == OP_MTHI)) HI <= A;
      if (accept && (mdop == OP_MTLO)) LO <= A;
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    md_stall = D_md && (busy || (start && (is_mul || is_div)));
    md_out   = '0;
    if (mdop == OP_MFHI) md_out = HI;
    if (mdop == OP_MFLO) md_out = LO;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Cycle-level scoreboard bench for mdu_ctrl: directed cases followed by random traffic,
// expectations come from a remaining-busy-cycles model using plain 64-bit arithmetic.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mdop = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        D_md = 1'b0;
  logic        busy, md_stall;
  logic [31:0] HI, LO, md_out;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .start(start), .mdop(mdop), .A(A), .B(B), .D_md(D_md),
    .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO), .md_out(md_out)
  );

  typedef struct packed {
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] out;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference state: architectural HI/LO, pending result, remaining busy cycles.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  bit          p_wr = 1'b0;
  int          busy_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy",     {31'd0, busy},     {31'd0, e.busy});
        chk("md_stall", {31'd0, md_stall}, {31'd0, e.stall});
        chk("HI",       HI,     e.hi);
        chk("LO",       LO,     e.lo);
        chk("md_out",   md_out, e.out);
      end
    end
  end

  task automatic model_edge(input logic r, input logic s, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    logic [63:0] prod;
    sa = a;
    sb = b;
    if (!r) begin
      m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_wr = 0; busy_left = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0 && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (s) begin
      case (op)
        4'd1, 4'd2: begin
          if (op == 4'd1) prod = 64'(longint'(sa) * longint'(sb));
          else            prod = 64'(a) * 64'(b);
          p_hi = prod[63:32]; p_lo = prod[31:0]; p_wr = 1; busy_left = MC;
        end
        4'd3, 4'd4: begin
          if (b == 0) begin
`ifdef MDU_DIV0_FAST_EN
            busy_left = 0;
`else
            p_wr = 0; busy_left = DC;
`endif
          end else begin
            if (op == 4'd3) begin
              p_lo = 32'(sa / sb); p_hi = 32'(sa % sb);
            end else begin
              p_lo = a / b; p_hi = a % b;
            end
            p_wr = 1; busy_left = DC;
          end
        end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic dm);
    exp_t e;
    rst = r; start = s; mdop = op; A = a; B = b; D_md = dm;
    e.busy  = (busy_left > 0);
    e.stall = dm && (e.busy || (s && op >= 4'd1 && op <= 4'd4));
    e.hi    = m_hi;
    e.lo    = m_lo;
    e.out   = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
    exp_q.push_back(e);
    model_edge(r, s, op, a, b);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic dm);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, (i % 2 == 0) ? 4'd7 : 4'd8, 32'd0, 32'd0, dm);
  endtask

  initial begin : stim
    logic [3:0]  op;
    logic [31:0] a, b;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    cyc(1'b0, 1'b1, 4'd1, 32'd3, 32'd3, 1'b1);

    cyc(1'b1, 1'b1, 4'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    idle(MC + 1, 1'b0);
    chk("spec_mult_hi", HI, 32'hFFFFFFFF);
    chk("spec_mult_lo", LO, 32'hFFFFFFF1);

    cyc(1'b1, 1'b1, 4'd4, 32'd7, 32'd2, 1'b0);
    idle(DC + 1, 1'b0);
    chk("spec_divu_lo", LO, 32'd3);
    chk("spec_divu_hi", HI, 32'd1);

    cyc(1'b1, 1'b1, 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    idle(DC + 1, 1'b0);
    chk("spec_div_lo", LO, 32'hFFFFFFFD);
    chk("spec_div_hi", HI, 32'hFFFFFFFF);

    cyc(1'b1, 1'b1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    idle(1, 1'b0);
    cyc(1'b1, 1'b1, 4'd6, 32'h1234, 32'd0, 1'b0);
    idle(MC, 1'b0);
    chk("spec_multu_hi", HI, 32'hFFFFFFFE);
    chk("spec_multu_lo", LO, 32'h00000001);

    cyc(1'b1, 1'b1, 4'd3, 32'd100, 32'd7, 1'b1);
    idle(DC + 2, 1'b1);

    cyc(1'b1, 1'b1, 4'd1, 32'd9, 32'd9, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    idle(MC + 2, 1'b0);
    chk("spec_rst_hi", HI, 32'd0);
    chk("spec_rst_lo", LO, 32'd0);

    cyc(1'b1, 1'b1, 4'd5, 32'hAA, 32'd0, 1'b1);
    cyc(1'b1, 1'b1, 4'd3, 32'd5, 32'd0, 1'b1);
    idle(DC + 1, 1'b1);
    chk("spec_div0_hi", HI, 32'hAA);

    for (int n = 0; n < 3000; n++) begin
      op = 4'($urandom_range(0, 8));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 9));
        3:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), op, a, b,
          1'($urandom_range(0, 1)));
    end
    idle(DC + 2, 1'b0);

    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
